muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_iter.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative 32x32 multiply / divide unit.
// One adder pass per cycle: shift-add multiply, restoring divide.

module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Ctr,
  output logic [31:0] Result,
  output logic        CF
);

  logic [32:0] sum;
  logic [31:0] bx;

  // Ctr=1 turns A+B into A-B; CF is carry on add, borrow on subtract
  always_comb begin
    bx     = B ^ {32{Ctr}};
    sum    = {1'b0, A} + {1'b0, bx} + {32'd0, Ctr};
    Result = sum[31:0];
    CF     = sum[32] ^ Ctr;
  end

endmodule

module muldiv_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] lq_q, lq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic [31:0] add_a;
  logic [31:0] add_res;
  logic        add_cf;
  logic        add_ctr;
  logic [31:0] rem_s;
  logic [31:0] mul_sum;
  logic        mul_c;
  logic        commit;
  logic        accept;

  // Two's complement without an adder: invert every bit above
  // the lowest set bit.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    logic seen;
    neg32 = '0;
    seen  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      neg32[i] = x[i] ^ seen;
      seen     = seen | x[i];
    end
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    logic seen;
    neg64 = '0;
    seen  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      neg64[i] = x[i] ^ seen;
      seen     = seen | x[i];
    end
  endfunction

  // The one shared adder: adds for multiply, subtracts for divide
  adder_32bit u_add (
    .A      (add_a),
    .B      (dvs_q),
    .Ctr    (add_ctr),
    .Result (add_res),
    .CF     (add_cf)
  );

  // Adder operand steering and per-iteration step results
  always_comb begin
    add_ctr = op_q[1];
    rem_s   = {acc_q[30:0], lq_q[31]};
    add_a   = op_q[1] ? rem_s : acc_q;
    mul_sum = lq_q[0] ? add_res : acc_q;
    mul_c   = lq_q[0] & add_cf;
    commit  = acc_q[31] | ~add_cf;
    accept  = start & ~busy;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    lq_d    = lq_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          cnt_d   = 5'd0;
          dz_d    = 1'b0;
          op_d    = op;
          sa_d    = op[0] & a[31];
          sb_d    = op[0] & b[31];
          acc_d   = 32'd0;
          lq_d    = (op[0] & a[31]) ? neg32(a) : a;
          dvs_d   = (op[0] & b[31]) ? neg32(b) : b;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
        if (op_q[1]) begin
          acc_d = commit ? add_res : rem_s;
          lq_d  = {lq_q[30:0], commit};
        end else begin
          acc_d = {mul_c, mul_sum[31:1]};
          lq_d  = {mul_sum[0], lq_q[31:1]};
        end
      end
      FIX: begin
        state_d = DONE;
        if (!op_q[1]) begin
          if (sa_q ^ sb_q) begin
            {hi_d, lo_d} = neg64({acc_q, lq_q});
          end else begin
            {hi_d, lo_d} = {acc_q, lq_q};
          end
        end else if (dvs_q == 32'd0) begin
          dz_d = 1'b1;
          lo_d = lq_q;
          hi_d = sa_q ? neg32(acc_q) : acc_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? neg32(lq_q) : lq_q;
          hi_d = sa_q ? neg32(acc_q) : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      lq_q    <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      lq_q    <= lq_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Outputs decoded from state and result registers
  always_comb begin
    busy = (state_q == CALC) | (state_q == FIX);
    done = (state_q == DONE);
    hi   = hi_q;
    lo   = lo_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter.
// Hand-computed results, latency and handshake checks.

module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  int tests = 0;
  int fails = 0;
  int lat;
  int bcyc;
  bit hold_ok;
  bit saw_done;

  muldiv_iter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [1:0]  o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input bit          inj);
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = ~x;
    b     = ~y;
    chk("dz_clr_on_accept", {63'd0, dz}, 64'd0);
    h0      = hi;
    l0      = lo;
    lat     = 0;
    bcyc    = 0;
    hold_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (inj && lat == 10) begin
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd1;
        b     = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic res(input string       tag,
                     input logic [31:0] eh,
                     input logic [31:0] el,
                     input logic        edz);
    chk({tag, ".lat"}, 64'(lat), 64'd33);
    chk({tag, ".hilo"}, {hi, lo}, {eh, el});
    chk({tag, ".dz"}, {63'd0, dz}, {63'd0, edz});
  endtask

  initial begin
    #12;
    chk("rst.hilo", {hi, lo}, 64'd0);
    chk("rst.flags", {61'd0, busy, done, dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    res("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
    chk("multu_max.busy", 64'(bcyc), 64'd33);
    chk("multu_max.hold", {63'd0, hold_ok}, 64'd1);
    @(posedge clk);
    #1;
    chk("done_pulse", {62'd0, done, busy}, 64'd0);

    run(2'b01, 32'hFFFFFFFD, 32'd7, 1'b0);
    res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    run(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
    res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    run(2'b10, 32'd100, 32'd7, 1'b0);
    res("divu", 32'd2, 32'd14, 1'b0);

    run(2'b10, 32'h00000064, 32'd0, 1'b0);
    res("divu_z", 32'h00000064, 32'hFFFFFFFF, 1'b1);

    run(2'b00, 32'd6, 32'd7, 1'b0);
    res("multu_b2b", 32'd0, 32'd42, 1'b0);

    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    res("div_ovf", 32'd0, 32'h80000000, 1'b0);

    run(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    res("mult_nn", 32'd0, 32'd6, 1'b0);

    run(2'b11, 32'd7, 32'hFFFFFFFE, 1'b0);
    res("div_pn", 32'd1, 32'hFFFFFFFD, 1'b0);

    run(2'b11, 32'hFFFFFFFB, 32'd0, 1'b0);
    res("div_z", 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    run(2'b00, 32'h12345678, 32'h10, 1'b1);
    res("ign_start", 32'd1, 32'h23456780, 1'b0);

    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd5;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.hilo", {hi, lo}, 64'd0);
    chk("abort.flags", {61'd0, busy, done, dz}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort.nodone", {63'd0, saw_done}, 64'd0);

    run(2'b10, 32'd9, 32'd3, 1'b0);
    res("divu_post", 32'd0, 32'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
